syscall_print_unit: RTL and testbench
=====================================

SYSCALL_PRINT_UNIT -- requirements
Module: syscall_print_unit

Interface
REQ-001 SHALL have parameter MAX_LEN, default 256: maximum characters emitted per print-string call before forced termination.
REQ-002 SHALL have parameter CNT_W, default 9: width of the character counter; it SHALL be able to hold MAX_LEN.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 sig_syscall  in  1  syscall request from the memory stage, valid for one cycle.
REQ-006 v0  in  32  service code, sampled when sig_syscall=1.
REQ-007 a0  in  32  argument (string address, integer, or char), sampled when sig_syscall=1.
REQ-008 mem_rd_en  out  1  data-memory read request.
REQ-009 mem_addr  out  32  word-aligned read address.
REQ-010 mem_rd_data  in  32  combinational read data, valid in the same cycle as mem_rd_en.
REQ-011 out_valid  out  1  output token valid.
REQ-012 out_kind  out  1  token kind: 0 = char, 1 = int.
REQ-013 out_data  out  32  token payload; chars are zero-extended.
REQ-014 out_ready  in  1  consumer accepts the token.
REQ-015 sig_stall  out  1  freeze request to the hazard unit.
REQ-016 sig_halt  out  1  sticky program-exit flag.

Function
REQ-017 Service codes SHALL be: 1 = print int, 4 = print string, 10 = exit, 11 = print char. Any other code SHALL be ignored, with no stall and no output.
REQ-018 States SHALL be IDLE, LOAD, EMIT, SINGLE and HALTED.
REQ-019 In IDLE with sig_syscall=1 and v0 in {1,4,11}, sig_stall SHALL assert combinationally in that same cycle.
REQ-020 For v0=1 or v0=11, the next state SHALL be SINGLE, with out_kind=1/out_data=a0 (v0=1) or out_kind=0/out_data={24'b0,a0[7:0]} (v0=11).
REQ-021 For v0=4, the next state SHALL be LOAD, with ptr<=a0 and count<=0.
REQ-022 For v0=10, the next state SHALL be HALTED; sig_halt SHALL be 1 from the next cycle until reset, and sig_stall SHALL stay 0.
REQ-023 LOAD SHALL drive mem_rd_en=1 and mem_addr={ptr[31:2],2'b00} for exactly one cycle, capture mem_rd_data, then go to EMIT.
REQ-024 Byte lanes SHALL be little-endian: byte = word[8*ptr[1:0] +: 8].
REQ-025 In EMIT, a byte equal to 0 SHALL produce no token and return to IDLE.
REQ-026 In EMIT, a nonzero byte SHALL set out_valid=1 and out_kind=0, held stable until out_ready=1.
REQ-027 On each EMIT handshake, ptr and count SHALL increment.
REQ-028 After an EMIT handshake, the next state SHALL be IDLE if count+1==MAX_LEN; otherwise LOAD if the new ptr[1:0]==0; otherwise EMIT.
REQ-029 SINGLE SHALL hold out_valid=1 until out_ready=1, then return to IDLE.
REQ-030 sig_stall SHALL be 1 in LOAD, EMIT and SINGLE, and 0 in IDLE and HALTED.
REQ-031 Stall release SHALL be the first cycle back in IDLE.
REQ-032 sig_syscall while not in IDLE SHALL be ignored.
REQ-033 In HALTED, all syscalls SHALL be ignored.
REQ-034 ptr SHALL wrap modulo 2^32 with no error.
REQ-035 Minimum print-char and print-int latency SHALL be: token visible 1 cycle after sig_syscall; stall released 2 cycles after sig_syscall when out_ready is held at 1.

Reset
REQ-036 rst SHALL force IDLE immediately, including mid-string.
REQ-037 rst SHALL force mem_rd_en, out_valid, out_kind, sig_stall and sig_halt to 0.
REQ-038 rst SHALL force mem_addr, out_data, ptr, count and the captured word to 0.
REQ-039 Reset SHALL emit no partial token after deassertion.

Configuration
REQ-040 With macro SYSCALL_PRINT_INT_EN defined, v0=1 SHALL behave per REQ-020.
REQ-041 With SYSCALL_PRINT_INT_EN undefined, v0=1 SHALL be treated as an unknown code per REQ-017, and out_kind SHALL be tied to 0.

Structure
REQ-042 A shared package SHALL hold the service-code constants (SYS_PRINT_INT=1, SYS_PRINT_STR=4, SYS_EXIT=10, SYS_PRINT_CHAR=11).
REQ-043 The same package SHALL hold the state enum and the out_kind encodings (OUT_CHAR=0, OUT_INT=1).
REQ-044 One sub-module, syscall_byte_sel, SHALL implement the combinational 32-bit word plus 2-bit offset to byte lane selection.

Verification
REQ-045 v0=11, a0=0x41, out_ready=1 -> one token {kind 0, data 0x41} at cycle+1; sig_stall high cycles 0 and 1 only.
REQ-046 v0=4, a0=0x100, mem[0x100]=0x00636261 -> tokens 'a','b','c' in order, one mem_rd_en cycle, then IDLE.
REQ-047 v0=4, a0=0x102, mem[0x100]=0x44430000, mem[0x104]=0x00000045 -> tokens 'C','D','E'; second read at mem_addr 0x104.
REQ-048 Print string with out_ready held low for 5 cycles -> out_valid and out_data stable throughout; no byte lost or duplicated.
REQ-049 v0=10 -> sig_halt=1 the next cycle; a subsequent v0=11 syscall produces no token; rst clears sig_halt.
REQ-050 rst asserted during EMIT of a 40-character string -> outputs 0 immediately; the next v0=11 syscall behaves per REQ-045.

Source files
------------

// File: rtl/syscall_print_unit_pkg.sv
// Shared definitions for the syscall print unit.
//   - Service codes decoded from v0
//   - FSM state encoding
//   - Token kind encodings carried on out_kind
package syscall_print_unit_pkg;

    localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
    localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
    localparam logic [31:0] SYS_EXIT       = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

    localparam logic OUT_CHAR = 1'b0;
    localparam logic OUT_INT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        EMIT   = 3'd2,
        SINGLE = 3'd3,
        HALTED = 3'd4
    } state_e;

endpackage

// File: rtl/syscall_print_unit_byte_sel.sv
// syscall_byte_sel: little-endian byte-lane extraction from a 32-bit word.
// Ports:
//   word     in  32  memory word
//   offset   in   2  byte offset within the word (address bits [1:0])
//   byte_out out  8  selected byte, lane 0 = bits [7:0]
module syscall_byte_sel (
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    output logic [7:0]  byte_out
);

    always_comb begin
        byte_out = word[7:0];
        case (offset)
            2'd0: byte_out = word[7:0];
            2'd1: byte_out = word[15:8];
            2'd2: byte_out = word[23:16];
            2'd3: byte_out = word[31:24];
            default: byte_out = word[7:0];
        endcase
    end

endmodule

// File: rtl/syscall_print_unit.sv
// syscall_print_unit: services print/exit syscalls raised by the memory stage.
// Print-char and print-int emit a single token; print-string walks memory a
// word at a time and emits one char token per nonzero byte until a NUL or
// MAX_LEN characters. The pipeline is frozen via sig_stall while busy.
//
// Optional feature: define SYSCALL_PRINT_INT_EN to enable the print-int
// service (v0=1). Without it, v0=1 is ignored and out_kind is always 0.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   sig_syscall, v0, a0 syscall request, service code, argument
//   mem_rd_en, mem_addr read request / word-aligned address
//   mem_rd_data         combinational read data (same cycle as mem_rd_en)
//   out_valid/kind/data token output, held until out_ready
//   out_ready           consumer handshake
//   sig_stall           freeze request to the hazard unit
//   sig_halt            sticky program-exit flag
module syscall_print_unit #(
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_syscall,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rd_data,
    output logic        out_valid,
    output logic        out_kind,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        sig_stall,
    output logic        sig_halt
);
    import syscall_print_unit_pkg::*;

    state_e            state_q, state_d;
    logic [31:0]       ptr_q, ptr_d;
    logic [31:0]       word_q, word_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              sig_halt_q, sig_halt_d;
`ifdef SYSCALL_PRINT_INT_EN
    logic              out_kind_q, out_kind_d;
`endif

    logic [31:0]       ptr_inc;
    logic [CNT_W:0]    count_inc;
    logic              last_char;
    logic [7:0]        load_byte;
    logic [7:0]        next_byte;

    // Codes that produce output and therefore freeze the pipeline.
    function automatic logic is_print_code(input logic [31:0] code);
`ifdef SYSCALL_PRINT_INT_EN
        return (code == SYS_PRINT_INT) || (code == SYS_PRINT_STR) ||
               (code == SYS_PRINT_CHAR);
`else
        return (code == SYS_PRINT_STR) || (code == SYS_PRINT_CHAR);
`endif
    endfunction

    assign ptr_inc   = ptr_q + 32'd1;
    assign count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};
    assign last_char = (count_inc == (CNT_W+1)'(MAX_LEN));

    // Byte at ptr taken straight from the bus while the word is being loaded,
    // so the first token of a word is ready the cycle EMIT is entered.
    syscall_byte_sel u_sel_load (
        .word     (mem_rd_data),
        .offset   (ptr_q[1:0]),
        .byte_out (load_byte)
    );

    // Byte at ptr+1 from the captured word, staged while the current token
    // handshakes so the next one appears without a bubble.
    syscall_byte_sel u_sel_next (
        .word     (word_q),
        .offset   (ptr_inc[1:0]),
        .byte_out (next_byte)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        word_d      = word_q;
        count_d     = count_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sig_halt_d  = sig_halt_q;
`ifdef SYSCALL_PRINT_INT_EN
        out_kind_d  = out_kind_q;
`endif

        case (state_q)
            IDLE: begin
                if (sig_syscall) begin
                    if (v0 == SYS_PRINT_CHAR) begin
                        state_d     = SINGLE;
                        out_valid_d = 1'b1;
                        out_data_d  = {24'b0, a0[7:0]};
`ifdef SYSCALL_PRINT_INT_EN
                        out_kind_d  = OUT_CHAR;
                    end else if (v0 == SYS_PRINT_INT) begin
                        state_d     = SINGLE;
                        out_valid_d = 1'b1;
                        out_data_d  = a0;
                        out_kind_d  = OUT_INT;
`endif
                    end else if (v0 == SYS_PRINT_STR) begin
                        state_d     = LOAD;
                        ptr_d       = a0;
                        count_d     = '0;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = {a0[31:2], 2'b00};
                    end else if (v0 == SYS_EXIT) begin
                        state_d    = HALTED;
                        sig_halt_d = 1'b1;
                    end
                end
            end

            LOAD: begin
                word_d      = mem_rd_data;
                state_d     = EMIT;
                out_valid_d = (load_byte != 8'd0);
                out_data_d  = {24'b0, load_byte};
`ifdef SYSCALL_PRINT_INT_EN
                out_kind_d  = OUT_CHAR;
`endif
            end

            EMIT: begin
                // No valid token here means the current byte is the NUL.
                if (!out_valid_q) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    ptr_d       = ptr_inc;
                    count_d     = count_inc[CNT_W-1:0];
                    out_valid_d = 1'b0;
                    if (last_char) begin
                        state_d = IDLE;
                    end else if (ptr_inc[1:0] == 2'b00) begin
                        state_d     = LOAD;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = {ptr_inc[31:2], 2'b00};
                    end else begin
                        state_d     = EMIT;
                        out_valid_d = (next_byte != 8'd0);
                        out_data_d  = {24'b0, next_byte};
                    end
                end
            end

            SINGLE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            HALTED: begin
                state_d = HALTED;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            word_q      <= '0;
            count_q     <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sig_halt_q  <= 1'b0;
`ifdef SYSCALL_PRINT_INT_EN
            out_kind_q  <= OUT_CHAR;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            word_q      <= word_d;
            count_q     <= count_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sig_halt_q  <= sig_halt_d;
`ifdef SYSCALL_PRINT_INT_EN
            out_kind_q  <= out_kind_d;
`endif
        end
    end

    // Stall is raised combinationally on the accepting cycle so the request
    // is frozen in place; it drops on the first cycle back in IDLE.
    assign sig_stall = (state_q == LOAD) || (state_q == EMIT) || (state_q == SINGLE) ||
                       ((state_q == IDLE) && sig_syscall && is_print_code(v0));

    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sig_halt  = sig_halt_q;
`ifdef SYSCALL_PRINT_INT_EN
    assign out_kind  = out_kind_q;
`else
    assign out_kind  = OUT_CHAR;
`endif

endmodule

// File: tb/tb_syscall_print_unit.sv
// Testbench for syscall_print_unit: table-driven single-token syscalls plus
// hand-written string, backpressure, wrap, length-limit, reset and halt
// sequences. Tokens are checked against a queue of expected results.
module tb_syscall_print_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_syscall;
    logic [31:0] v0, a0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rd_data;
    logic        out_valid, out_kind;
    logic [31:0] out_data;
    logic        out_ready;
    logic        sig_stall, sig_halt;

    logic [31:0] mem [0:255];

    syscall_print_unit dut (
        .clk         (clk),
        .rst         (rst),
        .sig_syscall (sig_syscall),
        .v0          (v0),
        .a0          (a0),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_kind    (out_kind),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .sig_stall   (sig_stall),
        .sig_halt    (sig_halt)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr[9:2]];

    typedef struct packed {
        logic        kind;
        logic [31:0] data;
    } tok_t;

    typedef struct {
        string       name;
        logic [31:0] v0;
        logic [31:0] a0;
        logic        exp_stall;
        logic        exp_tok;
        logic        exp_kind;
        logic [31:0] exp_data;
    } vec_t;

    tok_t        exp_q[$];
    logic [31:0] rd_addrs[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [31:0] prev_d = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard / protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_data", out_data, prev_d);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_token: got kind %0d data %h expected none", out_kind, out_data);
                end else begin
                    tok_t t;
                    t = exp_q.pop_front();
                    chk("tok_kind", {31'b0, out_kind}, {31'b0, t.kind});
                    chk("tok_data", out_data, t.data);
                end
            end
            if (mem_rd_en) rd_addrs.push_back(mem_addr);
            prev_v = out_valid;
            prev_r = out_ready;
            prev_d = out_data;
        end else begin
            prev_v = 1'b0;
        end
    end

    function automatic logic [7:0] pat_byte(input int j);
        return 8'h21 + 8'(j % 90);
    endfunction

    task automatic push_char(input logic [7:0] c);
        tok_t t;
        t.kind = 1'b0;
        t.data = {24'b0, c};
        exp_q.push_back(t);
    endtask

    // Drive one syscall for one cycle; returns stall/valid seen in that cycle.
    task automatic fire(input logic [31:0] code, input logic [31:0] arg,
                        output logic stall0, output logic valid0);
        @(posedge clk); #1;
        sig_syscall = 1'b1;
        v0 = code;
        a0 = arg;
        @(negedge clk);
        stall0 = sig_stall;
        valid0 = out_valid;
        @(posedge clk); #1;
        sig_syscall = 1'b0;
        v0 = '0;
        a0 = '0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (sig_stall && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'b0, sig_stall}, 32'd0);
    endtask

    task automatic run_single(input vec_t v);
        logic s0, val0;
        out_ready = 1'b1;
        if (v.exp_tok) exp_q.push_back({v.exp_kind, v.exp_data});
        fire(v.v0, v.a0, s0, val0);
        chk({v.name, "_stall0"}, {31'b0, s0}, {31'b0, v.exp_stall});
        chk({v.name, "_valid0"}, {31'b0, val0}, 32'd0);
        @(negedge clk);
        chk({v.name, "_valid1"}, {31'b0, out_valid}, {31'b0, v.exp_tok});
        chk({v.name, "_stall1"}, {31'b0, sig_stall}, {31'b0, v.exp_tok});
        @(negedge clk);
        chk({v.name, "_stall2"}, {31'b0, sig_stall}, 32'd0);
        chk({v.name, "_valid2"}, {31'b0, out_valid}, 32'd0);
        chk({v.name, "_drained"}, exp_q.size(), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        logic s0, val0;
        int   n;

        vecs[0] = '{"pchar_41", 32'd11, 32'h41, 1'b1, 1'b1, 1'b0, 32'h41};
        vecs[1] = '{"pchar_trunc", 32'd11, 32'hABCD_1234, 1'b1, 1'b1, 1'b0, 32'h34};
        vecs[2] = '{"pchar_zero", 32'd11, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0};
`ifdef SYSCALL_PRINT_INT_EN
        vecs[3] = '{"pint", 32'd1, 32'hFFFF_FFF6, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF6};
`else
        vecs[3] = '{"pint_off", 32'd1, 32'hFFFF_FFF6, 1'b0, 1'b0, 1'b0, 32'h0};
`endif
        vecs[4] = '{"unknown_7", 32'd7, 32'h41, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{"unknown_0", 32'd0, 32'h42, 1'b0, 1'b0, 1'b0, 32'h0};

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[64] = 32'h0063_6261;
        mem[65] = 32'h0000_0045;
        sig_syscall = 1'b0;
        v0 = '0;
        a0 = '0;
        out_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        #2;
        chk("rst_mem_rd_en", {31'b0, mem_rd_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_kind", {31'b0, out_kind}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_stall", {31'b0, sig_stall}, 32'd0);
        chk("rst_halt", {31'b0, sig_halt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_single(vecs[i]);

        // "abc" from an aligned word
        push_char(8'h61); push_char(8'h62); push_char(8'h63);
        rd_addrs.delete();
        fire(32'd4, 32'h100, s0, val0);
        chk("str_abc_stall0", {31'b0, s0}, 32'd1);
        wait_idle(50, "str_abc_idle");
        chk("str_abc_drained", exp_q.size(), 32'd0);
        chk("str_abc_reads", rd_addrs.size(), 32'd1);
        if (rd_addrs.size() >= 1) chk("str_abc_addr0", rd_addrs[0], 32'h100);

        // Unaligned start crossing into the next word
        mem[64] = 32'h4443_0000;
        push_char(8'h43); push_char(8'h44); push_char(8'h45);
        rd_addrs.delete();
        fire(32'd4, 32'h102, s0, val0);
        wait_idle(50, "str_cde_idle");
        chk("str_cde_drained", exp_q.size(), 32'd0);
        chk("str_cde_reads", rd_addrs.size(), 32'd2);
        if (rd_addrs.size() >= 2) begin
            chk("str_cde_addr0", rd_addrs[0], 32'h100);
            chk("str_cde_addr1", rd_addrs[1], 32'h104);
        end

        // Backpressure: out_ready low for 5 cycles while the first char waits
        mem[64] = 32'h0063_6261;
        out_ready = 1'b0;
        push_char(8'h61); push_char(8'h62); push_char(8'h63);
        fire(32'd4, 32'h100, s0, val0);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_valid_held", {31'b0, out_valid}, 32'd1);
        chk("bp_data_held", out_data, 32'h61);
        chk("bp_stall_held", {31'b0, sig_stall}, 32'd1);
        out_ready = 1'b1;
        wait_idle(50, "bp_idle");
        chk("bp_drained", exp_q.size(), 32'd0);

        // Pointer wraps from 0xFFFF_FFFF to 0
        mem[255] = 32'h5A59_0000;
        push_char(8'h59); push_char(8'h5A);
        rd_addrs.delete();
        fire(32'd4, 32'hFFFF_FFFE, s0, val0);
        wait_idle(50, "wrap_idle");
        chk("wrap_drained", exp_q.size(), 32'd0);
        chk("wrap_reads", rd_addrs.size(), 32'd2);
        if (rd_addrs.size() >= 2) begin
            chk("wrap_addr0", rd_addrs[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", rd_addrs[1], 32'h0);
        end

        // Length limit: 512 nonzero bytes available, only MAX_LEN=256 emitted
        for (int j = 0; j < 512; j++) mem[128 + j/4][8*(j%4) +: 8] = pat_byte(j);
        for (int j = 0; j < 256; j++) push_char(pat_byte(j));
        rd_addrs.delete();
        fire(32'd4, 32'h200, s0, val0);
        wait_idle(2000, "maxlen_idle");
        chk("maxlen_drained", exp_q.size(), 32'd0);
        chk("maxlen_reads", rd_addrs.size(), 32'd64);

        // Reset mid-string (40-char string at 0x80)
        for (int j = 0; j < 40; j++) mem[32 + j/4][8*(j%4) +: 8] = pat_byte(j);
        mem[42] = '0;
        for (int j = 0; j < 40; j++) push_char(pat_byte(j));
        fire(32'd4, 32'h80, s0, val0);
        repeat (10) @(posedge clk);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            if (out_valid) break;
            n++;
        end
        chk("mid_emit_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_stall", {31'b0, sig_stall}, 32'd0);
        chk("mid_rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_token", {31'b0, out_valid}, 32'd0);
        end
        run_single(vecs[0]);

        // Exit, then ignored syscall, then reset clears halt
        fire(32'd10, 32'h0, s0, val0);
        chk("exit_stall0", {31'b0, s0}, 32'd0);
        @(negedge clk);
        chk("exit_halt1", {31'b0, sig_halt}, 32'd1);
        chk("exit_stall1", {31'b0, sig_stall}, 32'd0);
        fire(32'd11, 32'h41, s0, val0);
        chk("halted_stall0", {31'b0, s0}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("halted_no_token", {31'b0, out_valid}, 32'd0);
            chk("halted_sticky", {31'b0, sig_halt}, 32'd1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("halt_cleared", {31'b0, sig_halt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_single(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
